kdf_seq_ctrl: RTL

Request sequencer between the hardware-performance test harness and the Hirose-PRESENT KDF core. It accepts one salt/count/password request over a valid/ready handshake and latches the operands. It then applies a clean KDF reset, runs the core until `end_signal`, and captures the 128-bit derived key with a cycle-accurate latency measurement. The result is returned over a second valid/ready handshake, so the harness no longer has to pulse the core's reset and poll its end flag itself.

---
 rtl/kdf_seq_pkg.sv | 24 ++
 rtl/kdf_seq_ctrl_sat_counter.sv | 23 ++
 rtl/kdf_seq_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/kdf_seq_pkg.sv
// Shared types and default widths for the KDF request sequencer.
package kdf_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } kdf_state_t;

    localparam int DEF_SALT_W     = 64;
    localparam int DEF_COUNT_W    = 32;
    localparam int DEF_PWD_W      = 32;
    localparam int DEF_KEY_W      = 128;
    localparam int DEF_CYC_W      = 32;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 1000000;

    // Counter width able to hold the value n (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/kdf_seq_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Clear has priority; count only while below the all-ones ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/kdf_seq_ctrl.sv
// Request sequencer for the Hirose-PRESENT KDF core: accepts one request,
// pulses the core reset, runs it to end_signal and returns the key plus the
// measured latency.
// Optional feature macro: KDF_SEQ_TIMEOUT_EN (RUN-state timeout).
//
// state | meaning
// IDLE  | ready for a request, core held in reset
// LOAD  | operands latched, core reset held for RST_CYCLES cycles
// RUN   | core released, latency counting, waiting for end
// DONE  | result presented until the consumer takes it
module kdf_seq_ctrl
    import kdf_seq_pkg::*;
#(
    parameter int SALT_W         = DEF_SALT_W,
    parameter int COUNT_W        = DEF_COUNT_W,
    parameter int PWD_W          = DEF_PWD_W,
    parameter int KEY_W          = DEF_KEY_W,
    parameter int CYC_W          = DEF_CYC_W,
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [SALT_W-1:0]  salt_i,
    input  logic [COUNT_W-1:0] count_i,
    input  logic [PWD_W-1:0]   pwd_i,
    output logic               kdf_rst_o,
    output logic [SALT_W-1:0]  kdf_salt_o,
    output logic [COUNT_W-1:0] kdf_count_o,
    output logic [PWD_W-1:0]   kdf_pwd_o,
    input  logic               kdf_end_i,
    input  logic [KEY_W-1:0]   kdf_key_i,
    output logic               key_valid_o,
    input  logic               key_ready_i,
    output logic [KEY_W-1:0]   key_o,
    output logic [CYC_W-1:0]   cycles_o,
    output logic               timeout_o,
    output logic               busy_o
);

    localparam int RST_W = cnt_width(RST_CYCLES);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

    // Elaboration-time parameter sanity.
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("kdf_seq_ctrl: RST_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("kdf_seq_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    kdf_state_t       state_q;
    kdf_state_t       state_d;
    logic             accept;
    logic             rst_done;
    logic             end_hit;
    logic             to_hit;
    logic             capture;
    logic [RST_W-1:0] rst_cnt;
    logic [CYC_W-1:0] lat_cnt;

    assign accept   = (state_q == IDLE) && req_valid_i;
    assign rst_done = (state_q == LOAD) && (rst_cnt == RST_LAST);
    assign end_hit  = (state_q == RUN) && kdf_end_i;
`ifdef KDF_SEQ_TIMEOUT_EN
    localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT_CYCLES - 1);
    // End on the same cycle as the limit wins, hence the !kdf_end_i term.
    assign to_hit   = (state_q == RUN) && !kdf_end_i && (lat_cnt == TO_LAST);
`else
    assign to_hit   = 1'b0;
`endif
    assign capture  = end_hit || to_hit;

    // Reset-pulse length: restarts at accept, advances through LOAD.
    sat_counter #(.W(RST_W)) u_rst_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == LOAD),
        .cnt   (rst_cnt)
    );

    // Core latency: zero on the first RUN cycle, frozen once end is seen.
    sat_counter #(.W(CYC_W)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rst_done),
        .en    ((state_q == RUN) && !kdf_end_i),
        .cnt   (lat_cnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs; the core sits in reset outside RUN.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        kdf_rst_o   = 1'b1;
        key_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (req_valid_i) state_d = LOAD;
            end
            LOAD: begin
                if (rst_done) state_d = RUN;
            end
            RUN: begin
                kdf_rst_o = 1'b0;
                if (capture) state_d = DONE;
            end
            DONE: begin
                key_valid_o = 1'b1;
                if (key_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, updated only when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kdf_salt_o  <= '0;
            kdf_count_o <= '0;
            kdf_pwd_o   <= '0;
        end else if (accept) begin
            kdf_salt_o  <= salt_i;
            kdf_count_o <= count_i;
            kdf_pwd_o   <= pwd_i;
        end
    end

    // Result capture; holds until the next capture so data is stable in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_o    <= '0;
            cycles_o <= '0;
        end else if (end_hit) begin
            key_o    <= kdf_key_i;
            cycles_o <= lat_cnt;
        end else if (to_hit) begin
            key_o    <= '0;
            cycles_o <= lat_cnt;
        end
    end

`ifdef KDF_SEQ_TIMEOUT_EN
    // Timeout flag qualifies the most recent capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_o <= 1'b0;
        end else if (capture) begin
            timeout_o <= to_hit;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

endmodule
